// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, req/ack word reads and a small
// prefetch FIFO whose head drives IR / ir_pc toward the decoder.
module instr_fetch #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] IR_BUBBLE = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] IR,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        br_en,
    input  logic [31:0] br_pc,
    input  logic [23:0] br_offset24,
    input  logic        redir_en,
    input  logic [31:0] redir_addr,
    output logic        align_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_addr;
    logic [31:0]   r_ir [DEPTH];
    logic [31:0]   r_pc [DEPTH];
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic          r_align_err;

    logic          w_redir;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_br_tgt;
    logic [31:0]   w_raw_tgt;
    logic [31:0]   w_tgt;
    logic [31:0]   w_pc_inc;
    logic [CW-1:0] w_count_nxt;

    // Absolute redirect outranks a relative branch in the same cycle
    assign w_redir   = redir_en | br_en;
    assign w_br_tgt  = br_pc + 32'd8
                     + {{6{br_offset24[23]}}, br_offset24, 2'b00};
    assign w_raw_tgt = redir_en ? redir_addr : w_br_tgt;
    assign w_tgt     = {w_raw_tgt[31:2], 2'b00};
    assign w_pc_inc  = r_fetch_pc + 32'd4;

    assign ir_valid    = (r_count != '0);
    assign w_pop       = ir_valid & ir_ready & ~w_redir;
    assign w_push      = (r_state == S_REQ) & mem_ack & ~w_redir;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    assign mem_req   = (r_state != S_IDLE);
    assign mem_addr  = r_addr;
    assign IR        = ir_valid ? r_ir[r_rptr] : IR_BUBBLE;
    assign ir_pc     = ir_valid ? r_pc[r_rptr] : 32'd0;
    assign align_err = r_align_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_VEC;
            r_addr      <= RESET_VEC;
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= w_redir & (w_raw_tgt[1:0] != 2'b00);
            if (w_redir) begin
                r_fetch_pc <= w_tgt;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (!w_redir && (r_count < FULL)) begin
                        r_state <= S_REQ;
                        r_addr  <= r_fetch_pc;
                    end
                end
                S_REQ: begin
                    if (w_redir) begin
                        r_state <= mem_ack ? S_IDLE : S_FLUSH;
                    end else if (mem_ack) begin
                        r_fetch_pc <= w_pc_inc;
                        if (w_count_nxt < FULL) begin
                            r_addr <= w_pc_inc;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_FLUSH: begin
                    // Stale read stays on the bus until acked, then dropped
                    if (mem_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ir[i] <= IR_BUBBLE;
                r_pc[i] <= 32'd0;
            end
        end else if (w_redir) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_ir[r_wptr] <= mem_rdata;
                r_pc[r_wptr] <= r_addr;
                r_wptr       <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: streaming, backpressure, branch,
// flush with late ack, combined redirect and reset-vector wrap.
`timescale 1ns/1ps
module tb_instr_fetch;
    localparam logic [31:0] BUB = 32'hF000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] IR;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        br_en;
    logic [31:0] br_pc;
    logic [23:0] br_offset24;
    logic        redir_en;
    logic [31:0] redir_addr;
    logic        align_err;

    logic        rst2;
    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic [31:0] ir2;
    logic [31:0] pc2;
    logic        valid2;
    logic        align2;

    int acks_done = 0;
    int ack_limit = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_ir_q[$];
    logic [31:0] got2[$];
    logic [31:0] mon_e;

    assign mem_ack   = mem_req && (acks_done < ack_limit);
    assign mem_rdata = ~mem_addr;
    assign ack2      = req2;
    assign rdata2    = ~addr2;

    instr_fetch dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .IR(IR), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready),
        .br_en(br_en), .br_pc(br_pc),
        .br_offset24(br_offset24),
        .redir_en(redir_en), .redir_addr(redir_addr),
        .align_err(align_err)
    );

    instr_fetch #(.RESET_VEC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst2),
        .mem_req(req2), .mem_addr(addr2),
        .mem_ack(ack2), .mem_rdata(rdata2),
        .IR(ir2), .ir_pc(pc2),
        .ir_valid(valid2), .ir_ready(1'b1),
        .br_en(1'b0), .br_pc(32'd0),
        .br_offset24(24'd0),
        .redir_en(1'b0), .redir_addr(32'd0),
        .align_err(align2)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (mem_req && mem_ack) acks_done <= acks_done + 1;
    end

    // Monitor: pops expectations whenever the DUT presents a transfer
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mem_req && mem_ack) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL addr_extra: got %h expected none",
                             mem_addr);
                end else begin
                    chk("mem_addr", mem_addr, exp_addr_q.pop_front());
                end
            end
            if (ir_valid && ir_ready && !br_en && !redir_en) begin
                if (exp_ir_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ir_extra: got %h expected none", ir_pc);
                end else begin
                    mon_e = exp_ir_q.pop_front();
                    chk("IR", IR, ~mon_e);
                    chk("ir_pc", ir_pc, mon_e);
                end
            end
            if (!ir_valid) begin
                chk("bubble_IR", IR, BUB);
                chk("bubble_pc", ir_pc, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst2 === 1'b1 && req2 && ack2 && got2.size() < 8)
            got2.push_back(addr2);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int nacks, input logic rdy);
        rst       = 1'b0;
        ir_ready  = rdy;
        br_en     = 1'b0;
        redir_en  = 1'b0;
        ack_limit = acks_done + nacks;
        cyc(2);
        rst = 1'b1;
    endtask

    task automatic wait_req(input string nm, input logic [31:0] a);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        chk({nm, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({nm, "_addr"}, mem_addr, a);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_addr_q.size() != 0 || exp_ir_q.size() != 0)
               && n < 50) begin
            cyc(1);
            n++;
        end
        chk({nm, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
        chk({nm, "_ir_left"}, 32'(exp_ir_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_ir_q.delete();
        cyc(3);
    endtask

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        ir_ready = 1'b0;
        br_en = 1'b0;
        br_pc = 32'd0;
        br_offset24 = 24'd0;
        redir_en = 1'b0;
        redir_addr = 32'd0;
        #1;
        rst = 1'b0;
        rst2 = 1'b0;
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_IR", IR, BUB);
        chk("rst_pc", ir_pc, 32'd0);
        chk("rst_align", {31'd0, align_err}, 32'd0);

        // T1: streaming, ack always, consumer always ready
        for (int i = 0; i < 5; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_ir_q.push_back(32'(i * 4));
        end
        start(5, 1'b1);
        @(negedge clk);
        chk("t1_req_c0", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("t1_req_c1", {31'd0, mem_req}, 32'd1);
        chk("t1_addr_c1", mem_addr, 32'd0);
        chk("t1_valid_c1", {31'd0, ir_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_c2", {31'd0, ir_valid}, 32'd1);
        drain("t1");
        chk("t1_next_addr", mem_addr, 32'h14);

        // T2: backpressure fills exactly DEPTH words
        for (int i = 0; i < 10; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_ir_q.push_back(32'(i * 4));
        end
        start(10, 1'b0);
        cyc(8);
        chk("t2_full_req", {31'd0, mem_req}, 32'd0);
        chk("t2_full_valid", {31'd0, ir_valid}, 32'd1);
        chk("t2_head_pc", ir_pc, 32'd0);
        chk("t2_head_IR", IR, 32'hFFFF_FFFF);
        ir_ready = 1'b1;
        wait_req("t2_resume", 32'h8);
        drain("t2");

        // T3: relative branch with negative offset flushes FIFO
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h100);
        exp_ir_q.push_back(32'h100);
        start(2, 1'b0);
        cyc(6);
        chk("t3_full_req", {31'd0, mem_req}, 32'd0);
        br_pc = 32'h100;
        br_offset24 = 24'hFFFFFE;
        br_en = 1'b1;
        cyc(1);
        br_en = 1'b0;
        chk("t3_flush_valid", {31'd0, ir_valid}, 32'd0);
        chk("t3_flush_IR", IR, BUB);
        chk("t3_flush_req", {31'd0, mem_req}, 32'd0);
        chk("t3_align", {31'd0, align_err}, 32'd0);
        ack_limit = ack_limit + 1;
        ir_ready = 1'b1;
        wait_req("t3_target", 32'h100);
        drain("t3");

        // T4: misaligned absolute redirect while 0x10 is outstanding
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_ir_q.push_back(32'(i * 4));
        end
        exp_addr_q.push_back(32'h10);
        exp_addr_q.push_back(32'h2000);
        exp_ir_q.push_back(32'h2000);
        start(4, 1'b1);
        cyc(10);
        redir_addr = 32'h2002;
        redir_en = 1'b1;
        cyc(1);
        redir_en = 1'b0;
        chk("t4_align_on", {31'd0, align_err}, 32'd1);
        chk("t4_flush_req", {31'd0, mem_req}, 32'd1);
        chk("t4_hold1", mem_addr, 32'h10);
        cyc(1);
        chk("t4_align_off", {31'd0, align_err}, 32'd0);
        chk("t4_hold2", mem_addr, 32'h10);
        cyc(1);
        chk("t4_hold3", mem_addr, 32'h10);
        ack_limit = ack_limit + 2;
        cyc(2);
        wait_req("t4_target", 32'h2000);
        drain("t4");

        // T5: redirect and branch together with a same-cycle ack
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h3000);
        exp_ir_q.push_back(32'h3000);
        start(1, 1'b0);
        cyc(5);
        redir_addr = 32'h3000;
        redir_en = 1'b1;
        br_pc = 32'h500;
        br_offset24 = 24'd0;
        br_en = 1'b1;
        ack_limit = ack_limit + 1;
        cyc(1);
        redir_en = 1'b0;
        br_en = 1'b0;
        chk("t5_valid", {31'd0, ir_valid}, 32'd0);
        chk("t5_req", {31'd0, mem_req}, 32'd0);
        chk("t5_IR", IR, BUB);
        chk("t5_align", {31'd0, align_err}, 32'd0);
        ack_limit = ack_limit + 1;
        ir_ready = 1'b1;
        wait_req("t5_target", 32'h3000);
        drain("t5");

        // T6: reset vector near top of memory, then async reset
        rst2 = 1'b1;
        cyc(8);
        if (got2.size() < 3) begin
            checks++;
            errors++;
            $display("FAIL t6_count: got %0d expected >=3", got2.size());
        end else begin
            chk("t6_a0", got2[0], 32'hFFFF_FFF8);
            chk("t6_a1", got2[1], 32'hFFFF_FFFC);
            chk("t6_a2", got2[2], 32'h0000_0000);
        end
        chk("t6_align", {31'd0, align2}, 32'd0);
        if (valid2) chk("t6_IR", ir2, ~pc2);
        @(negedge clk);
        chk("t6_req_before", {31'd0, req2}, 32'd1);
        #2;
        rst2 = 1'b0;
        #1;
        chk("t6_async_req", {31'd0, req2}, 32'd0);
        chk("t6_async_valid", {31'd0, valid2}, 32'd0);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
